// File: rtl/xor_slice_engine_74x86.sv
// Time-multiplexed XOR/XNOR engine: one SLICE-wide gate package processes a WIDTH-bit pair per NSLICE cycles.
// Optional even-parity output PAR is built when XSE_PARITY_EN is defined.
module xor_slice_engine_74x86 #(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic             CLK,
  input  logic             MR_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             INV,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Y,
  output logic             BUSY
`ifdef XSE_PARITY_EN
  ,
  output logic             PAR
`endif
);

  localparam int NSLICE = (WIDTH + SLICE - 1) / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic even_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  // Bits of the current slice; positions at or above WIDTH simply do not exist.
  function automatic logic [WIDTH-1:0] slice_mask(input logic [IDX_W-1:0] idx);
    logic [WIDTH-1:0] m;
    m = {WIDTH{1'b0}};
    for (int j = 0; j < WIDTH; j++) begin
      m[j] = ((j / SLICE) == int'(idx));
    end
    return m;
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, y_q, y_d;
  logic             inv_q, inv_d, out_valid_q, out_valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] mask_s, gate_s;
  logic             in_ready_s, load_s;
`ifdef XSE_PARITY_EN
  logic             par_q, par_d;
`endif

  assign in_ready_s = MR_N && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && OUT_READY));
  assign mask_s     = slice_mask(idx_q);
  assign gate_s     = (a_q ^ b_q) ^ {WIDTH{inv_q}};

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    inv_d       = inv_q;
    y_d         = y_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    load_s      = 1'b0;
`ifdef XSE_PARITY_EN
    par_d       = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (IN_VALID && in_ready_s) begin
          load_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        y_d = (y_q & ~mask_s) | (gate_s & mask_s);
`ifdef XSE_PARITY_EN
        par_d = par_q ^ even_parity(gate_s & mask_s);
`endif
        if (idx_q == LAST_IDX) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        // A drain may coincide with a new accept; that edge goes straight to RUN.
        if (OUT_READY) begin
          out_valid_d = 1'b0;
          if (IN_VALID) begin
            load_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
    if (load_s) begin
      state_d     = ST_RUN;
      a_d         = A;
      b_d         = B;
      inv_d       = INV;
      y_d         = {WIDTH{1'b0}};
      idx_d       = {IDX_W{1'b0}};
      out_valid_d = 1'b0;
`ifdef XSE_PARITY_EN
      par_d       = 1'b0;
`endif
    end else begin
      load_s = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge MR_N) begin
    if (!MR_N) begin
      state_q     <= ST_IDLE;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      inv_q       <= 1'b0;
      y_q         <= {WIDTH{1'b0}};
      idx_q       <= {IDX_W{1'b0}};
      out_valid_q <= 1'b0;
`ifdef XSE_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      inv_q       <= inv_d;
      y_q         <= y_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
`ifdef XSE_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign IN_READY  = in_ready_s;
  assign BUSY      = (state_q == ST_RUN);
  assign OUT_VALID = out_valid_q;
  assign Y         = y_q;
`ifdef XSE_PARITY_EN
  assign PAR       = par_q;
`endif

endmodule

// File: tb/tb_xor_slice_engine_74x86.sv
// Randomized self-checking bench for xor_slice_engine_74x86 across three geometries (8/4, 6/4, 8/8).
// Expected results come from a bitwise reference: (A ^ B ^ INV) masked to WIDTH, parity = XOR of result bits.
module tb_xor_slice_engine_74x86;

  logic       clk;
  logic       mr_n;
  logic       iv  [3];
  logic       orr [3];
  logic       inv [3];
  logic [7:0] a   [3];
  logic [7:0] b   [3];
  wire        ir_w   [3];
  wire        ov_w   [3];
  wire        busy_w [3];
  wire  [7:0] y_w    [3];
  wire  [5:0] y6_w;
  wire        par_w  [3];

  int nsl [3] = '{2, 2, 1};
  int wid [3] = '{8, 6, 8};
  int n_checks = 0;
  int n_pass   = 0;

  assign y_w[1] = {2'b00, y6_w};

  xor_slice_engine_74x86 #(.WIDTH(8), .SLICE(4)) dut0 (
    .CLK(clk), .MR_N(mr_n), .IN_VALID(iv[0]), .IN_READY(ir_w[0]), .A(a[0]), .B(b[0]),
    .INV(inv[0]), .OUT_VALID(ov_w[0]), .OUT_READY(orr[0]), .Y(y_w[0]), .BUSY(busy_w[0])
`ifdef XSE_PARITY_EN
    , .PAR(par_w[0])
`endif
  );

  xor_slice_engine_74x86 #(.WIDTH(6), .SLICE(4)) dut1 (
    .CLK(clk), .MR_N(mr_n), .IN_VALID(iv[1]), .IN_READY(ir_w[1]), .A(a[1][5:0]), .B(b[1][5:0]),
    .INV(inv[1]), .OUT_VALID(ov_w[1]), .OUT_READY(orr[1]), .Y(y6_w), .BUSY(busy_w[1])
`ifdef XSE_PARITY_EN
    , .PAR(par_w[1])
`endif
  );

  xor_slice_engine_74x86 #(.WIDTH(8), .SLICE(8)) dut2 (
    .CLK(clk), .MR_N(mr_n), .IN_VALID(iv[2]), .IN_READY(ir_w[2]), .A(a[2]), .B(b[2]),
    .INV(inv[2]), .OUT_VALID(ov_w[2]), .OUT_READY(orr[2]), .Y(y_w[2]), .BUSY(busy_w[2])
`ifdef XSE_PARITY_EN
    , .PAR(par_w[2])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [7:0] ref_y(input int d, input logic [7:0] av, input logic [7:0] bv,
                                       input logic iv_);
    logic [7:0] r;
    logic [7:0] m;
    r = av ^ bv;
    if (iv_) r = ~r;
    m = (wid[d] == 8) ? 8'hFF : 8'h3F;
    return r & m;
  endfunction

  task automatic check_par(input int d, input logic [7:0] exp);
`ifdef XSE_PARITY_EN
    check("par", {31'd0, par_w[d]}, {31'd0, ^exp});
`endif
  endtask

  // One full transaction with optional operand toggling during RUN and a stall before drain.
  task automatic do_op(input int d, input logic [7:0] av, input logic [7:0] bv, input logic iv_,
                       input bit toggle, input int stall);
    logic [7:0] exp;
    int cyc;
    exp = ref_y(d, av, bv, iv_);
    @(negedge clk);
    a[d] = av; b[d] = bv; inv[d] = iv_; iv[d] = 1'b1; orr[d] = 1'b0;
    #1 check("idle_ready", {31'd0, ir_w[d]}, 32'd1);
    @(posedge clk); #1;
    iv[d] = 1'b0;
    check("run_busy", {31'd0, busy_w[d]}, 32'd1);
    check("run_not_ready", {31'd0, ir_w[d]}, 32'd0);
    if (toggle) begin
      a[d] = 8'($urandom); b[d] = 8'($urandom); inv[d] = ~inv[d];
    end
    cyc = 0;
    while (!ov_w[d] && cyc < nsl[d] + 4) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", cyc, nsl[d]);
    check("y", {24'd0, y_w[d]}, {24'd0, exp});
    check_par(d, exp);
    repeat (stall) begin
      @(posedge clk); #1;
      check("hold_valid", {31'd0, ov_w[d]}, 32'd1);
      check("hold_y", {24'd0, y_w[d]}, {24'd0, exp});
      check_par(d, exp);
      check("hold_not_ready", {31'd0, ir_w[d]}, 32'd0);
    end
    orr[d] = 1'b1;
    #1 check("done_ready", {31'd0, ir_w[d]}, 32'd1);
    @(posedge clk); #1;
    orr[d] = 1'b0;
    check("drained", {31'd0, ov_w[d]}, 32'd0);
    check("idle_not_busy", {31'd0, busy_w[d]}, 32'd0);
  endtask

  // Back-to-back stream: drain and accept share an edge, each result NSLICE edges after its accept.
  task automatic b2b(input int d, input int n);
    logic [7:0] av [8];
    logic [7:0] bv [8];
    logic       ivv[8];
    for (int k = 0; k < n; k++) begin
      av[k] = 8'($urandom); bv[k] = 8'($urandom); ivv[k] = 1'($urandom);
    end
    @(negedge clk);
    a[d] = av[0]; b[d] = bv[0]; inv[d] = ivv[0]; iv[d] = 1'b1; orr[d] = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      check("b2b_accepted", {31'd0, busy_w[d]}, 32'd1);
      check("b2b_run_invalid", {31'd0, ov_w[d]}, 32'd0);
      if (k + 1 < n) begin
        a[d] = av[k+1]; b[d] = bv[k+1]; inv[d] = ivv[k+1];
      end else begin
        iv[d] = 1'b0;
      end
      repeat (nsl[d]) begin
        @(posedge clk); #1;
      end
      check("b2b_valid", {31'd0, ov_w[d]}, 32'd1);
      check("b2b_y", {24'd0, y_w[d]}, {24'd0, ref_y(d, av[k], bv[k], ivv[k])});
      check_par(d, ref_y(d, av[k], bv[k], ivv[k]));
    end
    @(posedge clk); #1;
    orr[d] = 1'b0;
    check("b2b_end_idle", {31'd0, ov_w[d]}, 32'd0);
    check("b2b_end_ready", {31'd0, ir_w[d]}, 32'd1);
  endtask

  initial begin
    mr_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; orr[d] = 1'b0; inv[d] = 1'b0; a[d] = 8'h00; b[d] = 8'h00;
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      check("rst_valid", {31'd0, ov_w[d]}, 32'd0);
      check("rst_y", {24'd0, y_w[d]}, 32'd0);
      check("rst_busy", {31'd0, busy_w[d]}, 32'd0);
      check("rst_ready", {31'd0, ir_w[d]}, 32'd0);
    end
    repeat (2) @(negedge clk);
    mr_n = 1'b1;
    #1 check("post_rst_ready", {31'd0, ir_w[0]}, 32'd1);

    do_op(0, 8'hA5, 8'h3C, 1'b0, 1'b0, 0);
    do_op(0, 8'hA5, 8'h3C, 1'b1, 1'b1, 0);
    do_op(1, 8'h3F, 8'h01, 1'b0, 1'b0, 0);
    do_op(0, 8'h12, 8'h34, 1'b0, 1'b0, 5);

    b2b(0, 3);
    b2b(2, 3);
    b2b(1, 3);

    // Abort mid-RUN (slice 1 pending) with an asynchronous reset pulse.
    @(negedge clk);
    a[0] = 8'hA5; b[0] = 8'h3C; inv[0] = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #2;
    mr_n = 1'b0;
    #1;
    check("abort_valid", {31'd0, ov_w[0]}, 32'd0);
    check("abort_y", {24'd0, y_w[0]}, 32'd0);
    check("abort_busy", {31'd0, busy_w[0]}, 32'd0);
    check("abort_ready", {31'd0, ir_w[0]}, 32'd0);
    @(negedge clk);
    mr_n = 1'b1;
    do_op(0, 8'hFF, 8'h0F, 1'b0, 1'b0, 0);

    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 10; k++) begin
        do_op(d, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
